inst_refill_ctrl: RTL and testbench

Memory-side refill engine for the level-1 instruction cache. On a cache miss it fetches the four 32-bit words of the missing 16-byte line from word-wide instruction memory, assembles a 128-bit line, and presents it with the line address and a one-cycle valid strobe to the cache's fill port. It sits between the fetch stage's miss signal and instruction memory, and holds `busy` high while a refill is in flight so the pipeline keeps issuing its no-operation.

---
 rtl/inst_refill_ctrl_pkg.sv | 14 +
 rtl/inst_refill_ctrl_line_assembler.sv | 33 +++
 rtl/inst_refill_ctrl.sv | 89 ++++++++
 tb/tb_inst_refill_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_refill_ctrl_pkg.sv
// Shared constants for the instruction-cache refill engine.
package inst_refill_ctrl_pkg;

  // Refill FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int LINE_BYTES = 16;

  // Instruction the fetch stage issues while a refill is in flight
  localparam logic [31:0] NOP_OPCODE = 32'h0800_0000;

endpackage

// File: rtl/inst_refill_ctrl_line_assembler.sv
// 4x32 write-by-index line register. A clear alongside a write zeroes every
// other slot, so a new line starts clean on its first word while the previous
// line stays visible until that moment.
module line_assembler #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_W     = 32,
  parameter int IW         = $clog2(LINE_WORDS)
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         we,
  input  logic                         clr,
  input  logic [IW-1:0]                idx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [LINE_WORDS*WORD_W-1:0] lineData
);

  logic [WORD_W-1:0] slot [LINE_WORDS];

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_slot
    localparam logic [IW-1:0] K = k;

    // Per-slot capture: write on index match, otherwise clear when asked
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)                 slot[k] <= '0;
      else if (we && idx == K) slot[k] <= wdata;
      else if (we && clr)      slot[k] <= '0;
    end

    assign lineData[k*WORD_W +: WORD_W] = slot[k];
  end

endmodule

// File: rtl/inst_refill_ctrl.sv
// L1 instruction-cache refill engine: fetches the four words of a missed
// 16-byte line, assembles them and strobes the line into the cache fill port.
module inst_refill_ctrl
  import inst_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  missValid,
  input  logic [ADDR_W-1:0]     missAddr,
  output logic                  memRead,
  output logic [ADDR_W-1:0]     memAddr,
  input  logic                  memReady,
  input  logic [31:0]           memRdata,
  output logic                  lineValid,
  output logic [ADDR_W-1:0]     lineAddr,
  output logic [LINE_WORDS*32-1:0] lineData,
  output logic                  busy
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lastLine;
  logic              lastValid;
  logic [ADDR_W-1:0] miss_base;
  logic              dup;
  logic              word_we;

  assign miss_base = missAddr & ~ADDR_W'(LINE_BYTES - 1);
  // The fetch stage re-presents the just-filled miss for a cycle; drop it
  assign dup       = lastValid && (miss_base == lastLine);
  assign word_we   = (state == FETCH) && memReady;

  assign memRead   = (state == FETCH);
  assign memAddr   = (state == FETCH) ? (base | ADDR_W'({cnt, 2'b00})) : '0;
  assign lineValid = (state == DONE);
  assign busy      = (state != IDLE);

  // Refill sequencing: accept miss, count words, strobe, record last line
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      lastLine  <= '0;
      lastValid <= 1'b0;
      lineAddr  <= '0;
    end else begin
      case (state)
        IDLE: if (missValid && !dup) begin
          base  <= miss_base;
          cnt   <= '0;
          state <= FETCH;
        end
        FETCH: if (memReady) begin
          if (cnt == LAST) begin
            state    <= DONE;
            lineAddr <= base;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          lastLine  <= base;
          lastValid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_assembler #(.LINE_WORDS(LINE_WORDS), .WORD_W(32)) u_asm (
    .Clk      (Clk),
    .Rst      (Rst),
    .we       (word_we),
    .clr      (cnt == '0),
    .idx      (cnt),
    .wdata    (memRdata),
    .lineData (lineData)
  );

endmodule

// File: tb/tb_inst_refill_ctrl.sv
// Scoreboard bench for inst_refill_ctrl: stimulus queues expected fills and
// read addresses, a negedge monitor pops and compares them.
module tb_inst_refill_ctrl;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         missValid;
  logic [31:0]  missAddr;
  logic         memRead;
  logic [31:0]  memAddr;
  logic         memReady;
  logic [31:0]  memRdata;
  logic         lineValid;
  logic [31:0]  lineAddr;
  logic [127:0] lineData;
  logic         busy;

  inst_refill_ctrl dut (
    .Clk(Clk), .Rst(Rst), .missValid(missValid), .missAddr(missAddr),
    .memRead(memRead), .memAddr(memAddr), .memReady(memReady), .memRdata(memRdata),
    .lineValid(lineValid), .lineAddr(lineAddr), .lineData(lineData), .busy(busy)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] L1230 = {32'hA5A5_123C, 32'hA5A5_1238, 32'hA5A5_1234, 32'hA5A5_1230};
  localparam logic [127:0] L1240 = {32'hA5A5_124C, 32'hA5A5_1248, 32'hA5A5_1244, 32'hA5A5_1240};
  localparam logic [127:0] L2000 = {32'hA5A5_200C, 32'hA5A5_2008, 32'hA5A5_2004, 32'hA5A5_2000};

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           lat;
    int           t0;
  } exp_t;

  exp_t        q_line[$];
  logic [31:0] q_addr[$];
  exp_t        e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fills = 0;

  // Memory model: data = addr ^ A5A5_0000, 'waits' low cycles before each word
  int   waits = 0;
  int   wcnt = 0;
  logic force_rdy = 1'b0;
  assign memRdata = memAddr ^ 32'hA5A5_0000;
  assign memReady = force_rdy | (memRead && wcnt >= waits);

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk or posedge Rst) begin
    if (Rst)                      wcnt <= 0;
    else if (memRead && memReady) wcnt <= 0;
    else if (memRead)             wcnt <= wcnt + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: fills, read addresses and address hold during waits
  logic        prev_rd = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge Clk) begin
    if (!Rst) begin
      if (lineValid) begin
        fills++;
        if (q_line.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_fill: got lineAddr %h expected no fill", lineAddr);
        end else begin
          e = q_line.pop_front();
          chk("lineAddr", lineAddr, e.addr);
          chk("lineData", lineData, e.data);
          chk("fill_latency", cyc - e.t0, e.lat);
        end
      end
      if (memRead && memReady) begin
        if (q_addr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_read: got memAddr %h expected no read", memAddr);
        end else chk("memAddr", memAddr, q_addr.pop_front());
      end
      if (memRead && prev_rd && !prev_rdy) chk("addr_hold", memAddr, prev_addr);
      prev_rd   = memRead;
      prev_rdy  = memReady;
      prev_addr = memAddr;
    end else prev_rd = 1'b0;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] la,
                       input logic [127:0] d, input int lat);
    exp_t x;
    @(posedge Clk); #1;
    missAddr  = a;
    missValid = 1'b1;
    x.addr = la; x.data = d; x.lat = lat; x.t0 = cyc;
    q_line.push_back(x);
    for (int i = 0; i < 4; i++) q_addr.push_back(la + 32'(4 * i));
  endtask

  task automatic wait_fills(input int target, input int bound);
    int n = 0;
    while (fills < target && n < bound) begin
      @(negedge Clk);
      n++;
    end
    if (fills < target) chk("fill_timeout", fills, target);
  endtask

  initial begin
    Rst = 1'b1; missValid = 1'b0; missAddr = '0;
    #12;
    // reset state
    chk("rst_memRead", memRead, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_lineValid", lineValid, 0);
    chk("rst_lineAddr", lineAddr, 0);
    chk("rst_lineData", lineData, 0);
    chk("rst_busy", busy, 0);
    @(posedge Clk); #1; Rst = 1'b0;

    // spurious memReady while idle
    force_rdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1; force_rdy = 1'b0;
    @(negedge Clk);
    chk("spur_busy", busy, 0);
    chk("spur_memRead", memRead, 0);
    chk("spur_lineData", lineData, 0);

    // zero-wait refill, missValid held across DONE (duplicate suppression)
    issue(32'h0000_1234, 32'h0000_1230, L1230, 5);
    wait_fills(1, 40);
    repeat (3) begin
      @(negedge Clk);
      chk("dup_busy", busy, 0);
    end
    chk("dup_fills", fills, 1);
    #1; missValid = 1'b0;

    // two wait cycles before each word; a different line starts a refill
    waits = 2;
    issue(32'h0000_1240, 32'h0000_1240, L1240, 13);
    @(negedge Clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      chk("wait_memRead", memRead, 1);
      if (i == 1) missValid = 1'b0;
    end
    wait_fills(2, 40);
    chk("wait_lineAddr_hold", lineAddr, 32'h0000_1240);

    // miss address changes while busy: ignored
    waits = 0;
    issue(32'h0000_1230, 32'h0000_1230, L1230, 5);
    @(posedge Clk); #1;
    @(posedge Clk); #1; missAddr = 32'h0000_2000;
    @(posedge Clk); #1;
    @(posedge Clk); #1; missValid = 1'b0;
    wait_fills(3, 40);
    repeat (2) @(negedge Clk);
    chk("busy_ignore_idle", busy, 0);
    chk("busy_ignore_fills", fills, 3);

    // reset after the first word aborts the refill
    issue(32'h0000_2000, 32'h0000_2000, L2000, 5);
    @(posedge Clk); #1; missValid = 1'b0;
    @(posedge Clk); #1; Rst = 1'b1;
    #1;
    chk("abort_memRead", memRead, 0);
    chk("abort_memAddr", memAddr, 0);
    chk("abort_lineValid", lineValid, 0);
    chk("abort_lineAddr", lineAddr, 0);
    chk("abort_lineData", lineData, 0);
    chk("abort_busy", busy, 0);
    q_line.delete();
    q_addr.delete();
    @(posedge Clk); #1; Rst = 1'b0;
    repeat (6) @(negedge Clk);
    chk("abort_fills", fills, 3);
    // same line as the last completed fill: only refills if lastValid cleared
    issue(32'h0000_1234, 32'h0000_1230, L1230, 5);
    @(posedge Clk); #1; missValid = 1'b0;
    wait_fills(4, 40);
    repeat (3) @(negedge Clk);
    chk("final_busy", busy, 0);
    chk("q_line_empty", q_line.size(), 0);
    chk("q_addr_empty", q_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
